// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the memory responder of the 16-bit
//                multicycle processor: default widths, FSM state encoding,
//                request-kind encoding and a strobe-decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10
    } kind_t;

    // True when two or more of the three request strobes are high.
    function automatic logic multi_strobe(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port synchronous RAM, word addressed. One write
//                port with enable and a registered read of the addressed word
//                on every rising edge (read-old on a same-edge write).
//                Contents are never reset.
//  Ports       : clk     - clock, rising edge
//                we_i    - write enable
//                addr_i  - word index
//                wdata_i - write data
//                rdata_o - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for the multicycle processor. Accepts
//                one fetch/load/store request at a time from the controller
//                strobes, waits WAIT_CYCLES wait states, then completes the
//                access against the unified instruction/data store.
//  Options     : MEM_ADDR_CHECK_EN - when defined, requests with addr >= DEPTH
//                are timed normally but suppress stores, return zero for
//                loads/fetches and pulse err together with resp_valid.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-low reset
//                IRWrite    - instruction-fetch strobe
//                MemRead    - load strobe
//                MemWrite   - store strobe
//                addr       - word address (upper bits above the index wrap)
//                wdata      - store data
//                instr      - last fetched instruction
//                rdata      - last loaded data word
//                resp_valid - one-cycle completion pulse
//                mem_ready  - high while a new request can be accepted
//                err        - one-cycle illegal-request pulse
//  Note        : ADDR_W must be larger than log2(DEPTH).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IRWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] rdata,
    output logic              resp_valid,
    output logic              mem_ready,
    output logic              err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              state_q;
    logic [3:0]          cnt_q;
    kind_t               kind_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                oob_q;
    logic [DATA_W-1:0]   instr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                resp_valid_q;
    logic                err_q;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic                w_any;
    logic                w_multi;
    kind_t               w_kind;
    logic                w_req_oob;

    assign w_any   = IRWrite | MemRead | MemWrite;
    assign w_multi = multi_strobe(IRWrite, MemRead, MemWrite);

    always_comb begin
        w_kind = KIND_FETCH;
        if (MemRead) begin
            w_kind = KIND_LOAD;
        end else if (MemWrite) begin
            w_kind = KIND_STORE;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    assign w_req_oob = |addr[ADDR_W-1:IDX_W];
`else
    // Upper address bits only matter for the range check; otherwise they wrap.
    logic w_addr_hi_unused;
    assign w_addr_hi_unused = ^addr[ADDR_W-1:IDX_W];
    assign w_req_oob        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Store access
    // The RAM has a registered read, so the word must be read on the edge that
    // enters RESP. In IDLE the live address is presented so a zero-wait
    // request reads on its own acceptance edge; otherwise the latched index.
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]    w_ram_addr;
    logic                w_ram_we;
    logic [DATA_W-1:0]   w_ram_rdata;

    assign w_ram_addr = (state_q == ST_IDLE) ? addr[IDX_W-1:0] : idx_q;
    assign w_ram_we   = (state_q == ST_RESP) && (kind_q == KIND_STORE) && !oob_q;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (w_ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Request FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            kind_q       <= KIND_FETCH;
            idx_q        <= '0;
            wdata_q      <= '0;
            oob_q        <= 1'b0;
            instr_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_multi) begin
                        err_q <= 1'b1;
                    end else if (w_any) begin
                        kind_q  <= w_kind;
                        idx_q   <= addr[IDX_W-1:0];
                        wdata_q <= wdata;
                        oob_q   <= w_req_oob;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b1;
                    err_q        <= oob_q;
                    case (kind_q)
                        KIND_FETCH: instr_q <= oob_q ? '0 : w_ram_rdata;
                        KIND_LOAD:  rdata_q <= oob_q ? '0 : w_ram_rdata;
                        default:    ; // store committed through w_ram_we
                    endcase
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr      = instr_q;
    assign rdata      = rdata_q;
    assign resp_valid = resp_valid_q;
    assign err        = err_q;
    assign mem_ready  = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Instance dut2 runs
//                with two wait states and a response scoreboard; dut0 runs
//                with zero wait states. Address-range behaviour follows
//                MEM_ADDR_CHECK_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_ir, a_rd, a_wr;
    logic [15:0] a_addr, a_wdata;
    logic [15:0] a_instr, a_rdata;
    logic        a_rv, a_rdy, a_err;

    logic        b_ir, b_rd, b_wr;
    logic [15:0] b_addr, b_wdata;
    logic [15:0] b_instr, b_rdata;
    logic        b_rv, b_rdy, b_err;

    int          total = 0;
    int          bad   = 0;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] m_mem [256];
    logic [15:0] m_instr;
    logic [15:0] m_rdata;

    mem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)
    ) dut2 (
        .clk(clk), .rst(rst_n),
        .IRWrite(a_ir), .MemRead(a_rd), .MemWrite(a_wr),
        .addr(a_addr), .wdata(a_wdata),
        .instr(a_instr), .rdata(a_rdata),
        .resp_valid(a_rv), .mem_ready(a_rdy), .err(a_err)
    );

    mem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst_n),
        .IRWrite(b_ir), .MemRead(b_rd), .MemWrite(b_wr),
        .addr(b_addr), .wdata(b_wdata),
        .instr(b_instr), .rdata(b_rdata),
        .resp_valid(b_rv), .mem_ready(b_rdy), .err(b_err)
    );

    // Scoreboard: every dut2 response pops one expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_rv === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_resp: resp_valid=1 with no request outstanding");
            end else begin
                mon_e = sb.pop_front();
                if (a_instr !== mon_e.instr || a_rdata !== mon_e.rdata || a_err !== mon_e.err) begin
                    bad++;
                    $display("FAIL sb_resp: got instr=%h rdata=%h err=%b, want instr=%h rdata=%h err=%b",
                             a_instr, a_rdata, a_err, mon_e.instr, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    // kind: 0 fetch, 1 load, 2 store
    task automatic push_expect(input int kind, input logic [15:0] ad, input logic [15:0] wd);
        exp_t e;
        bit   oob;
`ifdef MEM_ADDR_CHECK_EN
        oob = (ad >= 16'd256);
`else
        oob = 1'b0;
`endif
        case (kind)
            0:       m_instr = oob ? 16'h0000 : m_mem[ad[7:0]];
            1:       m_rdata = oob ? 16'h0000 : m_mem[ad[7:0]];
            default: if (!oob) m_mem[ad[7:0]] = wd;
        endcase
        e.instr = m_instr;
        e.rdata = m_rdata;
        e.err   = oob;
        sb.push_back(e);
    endtask

    task automatic issue2(input int kind, input logic [15:0] ad, input logic [15:0] wd, input string nm);
        int n;
        int nlow;
        bit seen;
        @(negedge clk);
        total++;
        if (a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: mem_ready=%b want 1", nm, a_rdy);
        end
        push_expect(kind, ad, wd);
        a_ir = (kind == 0); a_rd = (kind == 1); a_wr = (kind == 2);
        a_addr = ad; a_wdata = wd;
        @(posedge clk); #1;
        a_ir = 1'b0; a_rd = 1'b0; a_wr = 1'b0;
        nlow = (a_rdy === 1'b0) ? 1 : 0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (a_rv === 1'b1) seen = 1'b1;
            else if (a_rdy === 1'b0) nlow++;
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL %s_latency: resp after %0d edges, want 3", nm, n);
        end
        total++;
        if (nlow !== 3 || a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_low: low %0d cycles ready=%b, want 3 cycles ready=1", nm, nlow, a_rdy);
        end
    endtask

    task automatic issue0(input int kind, input logic [15:0] ad, input logic [15:0] wd,
                          input logic [15:0] ei, input logic [15:0] er, input string nm);
        int n;
        int nlow;
        bit seen;
        @(negedge clk);
        b_ir = (kind == 0); b_rd = (kind == 1); b_wr = (kind == 2);
        b_addr = ad; b_wdata = wd;
        @(posedge clk); #1;
        b_ir = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        nlow = (b_rdy === 1'b0) ? 1 : 0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (b_rv === 1'b1) seen = 1'b1;
            else if (b_rdy === 1'b0) nlow++;
        end
        total++;
        if (n !== 1 || nlow !== 1) begin
            bad++;
            $display("FAIL %s_w0_timing: edges=%0d ready_low=%0d, want 1 and 1", nm, n, nlow);
        end
        total++;
        if (b_instr !== ei || b_rdata !== er || b_err !== 1'b0 || b_rdy !== 1'b1) begin
            bad++;
            $display("FAIL %s_w0_data: instr=%h rdata=%h err=%b ready=%b, want %h %h 0 1",
                     nm, b_instr, b_rdata, b_err, b_rdy, ei, er);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_ir = 0; a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_ir = 0; b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        m_instr = '0; m_rdata = '0;
        #12;
        total++;
        if ({a_instr, a_rdata, a_rv, a_err, a_rdy} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_dut2: instr=%h rdata=%h rv=%b err=%b rdy=%b, want 0 0 0 0 1",
                     a_instr, a_rdata, a_rv, a_err, a_rdy);
        end
        total++;
        if ({b_instr, b_rdata, b_rv, b_err, b_rdy} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_dut0: instr=%h rdata=%h rv=%b err=%b rdy=%b, want 0 0 0 0 1",
                     b_instr, b_rdata, b_rv, b_err, b_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        issue2(2, 16'h0005, 16'h1234, "store5");
        issue2(1, 16'h0005, 16'h0000, "load5");
        issue2(0, 16'h0005, 16'h0000, "fetch5");
        issue2(2, 16'h0010, 16'h1111, "store10");
    endtask

    task automatic test_wait0();
        issue0(2, 16'h0003, 16'hA5C3, 16'h0000, 16'h0000, "store3");
        issue0(0, 16'h0003, 16'h0000, 16'hA5C3, 16'h0000, "fetch3");
        issue0(1, 16'h0003, 16'h0000, 16'hA5C3, 16'hA5C3, "load3");
    endtask

    task automatic test_multi_strobe();
        @(negedge clk);
        a_rd = 1'b1; a_wr = 1'b1; a_addr = 16'h0005; a_wdata = 16'hDEAD;
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0;
        total++;
        if (a_err !== 1'b1 || a_rv !== 1'b0 || a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL multi_err_pulse: err=%b rv=%b rdy=%b, want 1 0 1", a_err, a_rv, a_rdy);
        end
        @(posedge clk); #1;
        total++;
        if (a_err !== 1'b0 || a_rv !== 1'b0 || a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL multi_err_end: err=%b rv=%b rdy=%b, want 0 0 1", a_err, a_rv, a_rdy);
        end
        issue2(1, 16'h0005, 16'h0000, "load5_after_multi");
    endtask

    // drop_at: edge index (after acceptance edge 0) at which the strobe falls.
    task automatic held_strobe(input int drop_at, input int exp_cnt, input int exp_second, input string nm);
        int cnt;
        int first;
        int second;
        cnt = 0; first = -1; second = -1;
        @(negedge clk);
        push_expect(1, 16'h0005, 16'h0000);
        if (exp_cnt > 1) push_expect(1, 16'h0005, 16'h0000);
        a_rd = 1'b1; a_addr = 16'h0005;
        @(posedge clk);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (a_rv === 1'b1) begin
                cnt++;
                if (cnt == 1) first = e;
                else second = e;
            end
            if (e == drop_at) a_rd = 1'b0;
        end
        total++;
        if (cnt !== exp_cnt || first !== 3 || second !== exp_second) begin
            bad++;
            $display("FAIL %s: responses=%0d first=%0d second=%0d, want %0d 3 %0d",
                     nm, cnt, first, second, exp_cnt, exp_second);
        end
    endtask

    task automatic test_back_to_back();
        held_strobe(3, 1, -1, "held_single");
        held_strobe(4, 2, 7, "held_reaccept");
    endtask

    task automatic test_alias();
        issue2(2, 16'h0105, 16'h7777, "store105");
        issue2(1, 16'h0005, 16'h0000, "load5_alias");
        issue2(1, 16'h0105, 16'h0000, "load105");
        issue2(0, 16'h0105, 16'h0000, "fetch105");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a_wr = 1'b1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
        @(posedge clk); #1;
        a_wr = 1'b0;
        @(posedge clk); #1;
        total++;
        if (a_rdy !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_wait: mem_ready=%b want 0", a_rdy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({a_instr, a_rdata, a_rv, a_err, a_rdy} !== {16'h0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL abort_reset_outputs: instr=%h rdata=%h rv=%b err=%b rdy=%b, want 0 0 0 0 1",
                     a_instr, a_rdata, a_rv, a_err, a_rdy);
        end
        m_instr = '0; m_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue2(1, 16'h0010, 16'h0000, "load10_after_abort");
        total++;
        if (a_rdata === 16'hBEEF) begin
            bad++;
            $display("FAIL abort_not_committed: rdata=%h, want anything but beef", a_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wait0();
        test_multi_strobe();
        test_back_to_back();
        test_alias();
        test_reset_abort();
        repeat (3) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses missing, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit multicycle processor; the slave end of the controller's IRWrite/MemRead/MemWrite strobes.
- Accepts one instruction-fetch, load or store request at a time and services it after a programmable number of wait states.
- Returns fetched instruction and load data in registers, and gives the controller a ready/stall indication.
- Contains the unified word-addressed instruction/data store.

Parameters:
- DATA_W, 16, data and instruction word width
- ADDR_W, 16, request address width
- DEPTH, 256, number of words in the store (power of two)
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- IRWrite  in  1  instruction-fetch request strobe
- MemRead  in  1  data-load request strobe
- MemWrite  in  1  data-store request strobe
- addr  in  ADDR_W  word address of the request
- wdata  in  DATA_W  store data
- instr  out  DATA_W  last fetched instruction word
- rdata  out  DATA_W  last loaded data word
- resp_valid  out  1  one-cycle pulse: request completed
- mem_ready  out  1  high when a new request can be accepted
- err  out  1  one-cycle pulse: illegal request

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, instr=0, rdata=0, resp_valid=0, err=0, mem_ready=1.
  - Any in-flight request is aborted; an aborted store is never committed.
  - Store contents are not cleared.
- States: IDLE, WAIT, RESP. mem_ready = (state==IDLE).
- IDLE:
  - Exactly one strobe high: latch kind (FETCH/LOAD/STORE), addr and wdata; counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - Two or more strobes high: request rejected, err=1 for the next cycle, remain in IDLE.
  - No strobes high: remain in IDLE.
- WAIT: counter decrements each cycle; when the counter reaches 1, next state is RESP.
- RESP (exactly one cycle, then IDLE):
  - STORE: store[index] <= latched wdata on this edge.
  - LOAD: rdata <= store[index].
  - FETCH: instr <= store[index].
  - resp_valid=1 during the cycle after the RESP edge, i.e. registered and coincident with the updated instr/rdata.
- Latency: request sampled at edge T; resp_valid high in cycle T+WAIT_CYCLES+2; mem_ready returns high in the same cycle as resp_valid.
  - Consequence: a back-to-back request can be accepted in the resp_valid cycle.
- Strobes while not in IDLE are ignored (no err). The controller must hold its state until resp_valid.
- instr and rdata hold their values between responses; a store changes neither.
- Index = addr[log2(DEPTH)-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
- Read-after-write to the same address returns the new data, because the write commits before any later request is accepted.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined: a request whose addr >= DEPTH is accepted and timed normally, but at RESP:
  - a store is suppressed;
  - a load or fetch writes 0 to rdata/instr;
  - err pulses together with resp_valid.
- Undefined: no range check; addresses wrap as above; err is raised only by multiple simultaneous strobes.

Decomposition:
- Shared package (mem_pkg):
  - DATA_W/ADDR_W constants;
  - state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10);
  - request-kind encoding (FETCH=2'b00, LOAD=2'b01, STORE=2'b10).
- One sub-module, mem_array: a single-port synchronous RAM with a write enable and a registered read. mem_responder holds the FSM, counter, request latches and output registers.

Test Plan:
- Reset during WAIT of a store to addr 0x0010 (wdata 0xBEEF) → all outputs return to reset values immediately; a later load of 0x0010 does not return 0xBEEF.
- WAIT_CYCLES=2: MemWrite addr 0x0005 wdata 0x1234, then MemRead 0x0005 → resp_valid for each exactly 4 cycles after acceptance; rdata=0x1234; instr unchanged.
- WAIT_CYCLES=0: IRWrite addr 0x0003 (store preloaded 0xA5C3) → resp_valid 2 cycles after acceptance; instr=0xA5C3; mem_ready low for exactly 1 cycle.
- MemRead and MemWrite high together in IDLE → err pulses 1 cycle later; no resp_valid; store unchanged; mem_ready stays 1.
- Strobe held high through WAIT → exactly one response; the request is re-accepted only in the resp_valid cycle.
- Address 0x0105 with DEPTH=256:
  - without the macro, a store aliases to 0x0005;
  - with MEM_ADDR_CHECK_EN, err and resp_valid pulse together, the store is suppressed, and a load returns rdata=0.
